// File: rtl/alu_rsv_station.sv
// ALU reservation station: buffers dispatched ops, snoops ALU/LSB CDBs, issues one ready op per cycle.
// Build option: define ALU_RS_OLDEST_FIRST_EN to issue the oldest ready entry (age matrix); default is lowest index.
module alu_rsv_station #(
  parameter int unsigned RS_SIZE = 16,
  parameter int unsigned OP_W    = 6,
  parameter int unsigned ROB_W   = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              disp_valid,
  input  logic [OP_W-1:0]   disp_op_id,
  input  logic [ADDR_W-1:0] disp_pc,
  input  logic [DATA_W-1:0] disp_vj,
  input  logic [DATA_W-1:0] disp_vk,
  input  logic              disp_rj,
  input  logic              disp_rk,
  input  logic [ROB_W-1:0]  disp_qj,
  input  logic [ROB_W-1:0]  disp_qk,
  input  logic [DATA_W-1:0] disp_imm,
  input  logic [ROB_W-1:0]  disp_rob_id,
  output logic              rs_full,
  input  logic              alu_cdb_valid,
  input  logic [ROB_W-1:0]  alu_cdb_rob_id,
  input  logic [DATA_W-1:0] alu_cdb_value,
  input  logic              lsb_cdb_valid,
  input  logic [ROB_W-1:0]  lsb_cdb_rob_id,
  input  logic [DATA_W-1:0] lsb_cdb_value,
  output logic              rs_out_valid,
  output logic [OP_W-1:0]   rs_out_op_id,
  output logic [ADDR_W-1:0] rs_out_pc,
  output logic [DATA_W-1:0] rs_out_rs1,
  output logic [DATA_W-1:0] rs_out_rs2,
  output logic [DATA_W-1:0] rs_out_imm,
  output logic [ROB_W-1:0]  rs_out_rob_id,
  input  logic              rob_rollback
);

  localparam int unsigned IDX_W = $clog2(RS_SIZE);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [RS_SIZE-1:0] busy_q, rj_q, rk_q;
  logic [OP_W-1:0]    op_q  [RS_SIZE];
  logic [ADDR_W-1:0]  pc_q  [RS_SIZE];
  logic [DATA_W-1:0]  vj_q  [RS_SIZE];
  logic [DATA_W-1:0]  vk_q  [RS_SIZE];
  logic [DATA_W-1:0]  imm_q [RS_SIZE];
  logic [ROB_W-1:0]   qj_q  [RS_SIZE];
  logic [ROB_W-1:0]   qk_q  [RS_SIZE];
  logic [ROB_W-1:0]   rob_q [RS_SIZE];

  logic              out_valid_q, full_q;
  logic [OP_W-1:0]   out_op_q;
  logic [ADDR_W-1:0] out_pc_q;
  logic [DATA_W-1:0] out_rs1_q, out_rs2_q, out_imm_q;
  logic [ROB_W-1:0]  out_rob_q;

  logic [RS_SIZE-1:0] ready_c, busy_d;
  logic               iss_found_c, alloc_found_c, alloc_c;
  logic [IDX_W-1:0]   iss_idx_c, alloc_idx_c;
  logic [CNT_W-1:0]   free_cnt_c;

  assign rs_full       = full_q;
  assign rs_out_valid  = out_valid_q;
  assign rs_out_op_id  = out_op_q;
  assign rs_out_pc     = out_pc_q;
  assign rs_out_rs1    = out_rs1_q;
  assign rs_out_rs2    = out_rs2_q;
  assign rs_out_imm    = out_imm_q;
  assign rs_out_rob_id = out_rob_q;

  // ALU broadcast takes precedence when both buses carry the same ROB id
  function automatic logic cdb_hit(input logic [ROB_W-1:0] q);
    return (alu_cdb_valid && (alu_cdb_rob_id == q)) || (lsb_cdb_valid && (lsb_cdb_rob_id == q));
  endfunction

  function automatic logic [DATA_W-1:0] cdb_val(input logic [ROB_W-1:0] q);
    return (alu_cdb_valid && (alu_cdb_rob_id == q)) ? alu_cdb_value : lsb_cdb_value;
  endfunction

  assign ready_c = busy_q & rj_q & rk_q;

`ifdef ALU_RS_OLDEST_FIRST_EN
  // age_q[j][i] = 1 means entry j was allocated before entry i
  logic [RS_SIZE-1:0] age_q [RS_SIZE];
  logic [RS_SIZE-1:0] age_d [RS_SIZE];
  logic               has_older_c;

  always_comb begin
    iss_found_c = 1'b0;
    iss_idx_c   = '0;
    has_older_c = 1'b0;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      has_older_c = 1'b0;
      for (int j = 0; j < int'(RS_SIZE); j++) begin
        if ((j != i) && ready_c[j] && age_q[j][i]) has_older_c = 1'b1;
      end
      if (ready_c[i] && !has_older_c && !iss_found_c) begin
        iss_found_c = 1'b1;
        iss_idx_c   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    age_d = age_q;
    if (iss_found_c) age_d[iss_idx_c] = '0;
    if (alloc_c) begin
      for (int j = 0; j < int'(RS_SIZE); j++) age_d[j][alloc_idx_c] = 1'b1;
      age_d[alloc_idx_c] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q <= '{default: '0};
    end else if (rdy) begin
      if (rob_rollback) age_q <= '{default: '0};
      else              age_q <= age_d;
    end
  end
`else
  always_comb begin
    iss_found_c = 1'b0;
    iss_idx_c   = '0;
    for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
      if (ready_c[i]) begin
        iss_found_c = 1'b1;
        iss_idx_c   = IDX_W'(i);
      end
    end
  end
`endif

  // Allocation looks only at entries free before this edge
  always_comb begin
    alloc_found_c = 1'b0;
    alloc_idx_c   = '0;
    for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        alloc_found_c = 1'b1;
        alloc_idx_c   = IDX_W'(i);
      end
    end
    alloc_c = disp_valid && alloc_found_c;
  end

  always_comb begin
    busy_d = busy_q;
    if (iss_found_c) busy_d[iss_idx_c] = 1'b0;
    if (alloc_c)     busy_d[alloc_idx_c] = 1'b1;
    free_cnt_c = '0;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      if (!busy_d[i]) free_cnt_c = free_cnt_c + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      rj_q        <= '0;
      rk_q        <= '0;
      out_valid_q <= 1'b0;
      full_q      <= 1'b0;
      out_op_q    <= '0;
      out_pc_q    <= '0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      out_imm_q   <= '0;
      out_rob_q   <= '0;
    end else if (rdy) begin
      if (rob_rollback) begin
        busy_q      <= '0;
        out_valid_q <= 1'b0;
        full_q      <= 1'b0;
      end else begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
          if (busy_q[i] && !rj_q[i] && cdb_hit(qj_q[i])) begin
            vj_q[i] <= cdb_val(qj_q[i]);
            rj_q[i] <= 1'b1;
          end
          if (busy_q[i] && !rk_q[i] && cdb_hit(qk_q[i])) begin
            vk_q[i] <= cdb_val(qk_q[i]);
            rk_q[i] <= 1'b1;
          end
        end
        out_valid_q <= iss_found_c;
        if (iss_found_c) begin
          out_op_q  <= op_q[iss_idx_c];
          out_pc_q  <= pc_q[iss_idx_c];
          out_rs1_q <= vj_q[iss_idx_c];
          out_rs2_q <= vk_q[iss_idx_c];
          out_imm_q <= imm_q[iss_idx_c];
          out_rob_q <= rob_q[iss_idx_c];
        end
        if (alloc_c) begin
          op_q[alloc_idx_c]  <= disp_op_id;
          pc_q[alloc_idx_c]  <= disp_pc;
          imm_q[alloc_idx_c] <= disp_imm;
          rob_q[alloc_idx_c] <= disp_rob_id;
          qj_q[alloc_idx_c]  <= disp_qj;
          qk_q[alloc_idx_c]  <= disp_qk;
          if (!disp_rj && cdb_hit(disp_qj)) begin
            vj_q[alloc_idx_c] <= cdb_val(disp_qj);
            rj_q[alloc_idx_c] <= 1'b1;
          end else begin
            vj_q[alloc_idx_c] <= disp_vj;
            rj_q[alloc_idx_c] <= disp_rj;
          end
          if (!disp_rk && cdb_hit(disp_qk)) begin
            vk_q[alloc_idx_c] <= cdb_val(disp_qk);
            rk_q[alloc_idx_c] <= 1'b1;
          end else begin
            vk_q[alloc_idx_c] <= disp_vk;
            rk_q[alloc_idx_c] <= disp_rk;
          end
        end
        busy_q <= busy_d;
        full_q <= (free_cnt_c <= CNT_W'(1));
      end
    end
  end

endmodule

// File: tb/tb_alu_rsv_station.sv
// Self-checking bench for alu_rsv_station: directed vector table, corner sequences, randomized model check.
module tb_alu_rsv_station;

  localparam int RS = 16;
  localparam logic [5:0] OP_ADDI = 6'd10;
  localparam logic [5:0] OP_ADD  = 6'd19;

  logic        clk = 1'b0;
  logic        rst, rdy, disp_valid, disp_rj, disp_rk;
  logic [5:0]  disp_op_id;
  logic [31:0] disp_pc, disp_vj, disp_vk, disp_imm;
  logic [3:0]  disp_qj, disp_qk, disp_rob_id;
  logic        rs_full;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [3:0]  alu_cdb_rob_id, lsb_cdb_rob_id;
  logic [31:0] alu_cdb_value, lsb_cdb_value;
  logic        rs_out_valid;
  logic [5:0]  rs_out_op_id;
  logic [31:0] rs_out_pc, rs_out_rs1, rs_out_rs2, rs_out_imm;
  logic [3:0]  rs_out_rob_id;
  logic        rob_rollback;

  int checks = 0;
  int errors = 0;

  alu_rsv_station dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .disp_valid(disp_valid), .disp_op_id(disp_op_id), .disp_pc(disp_pc),
    .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_rj(disp_rj), .disp_rk(disp_rk),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_imm(disp_imm), .disp_rob_id(disp_rob_id),
    .rs_full(rs_full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_id(alu_cdb_rob_id), .alu_cdb_value(alu_cdb_value),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_id(lsb_cdb_rob_id), .lsb_cdb_value(lsb_cdb_value),
    .rs_out_valid(rs_out_valid), .rs_out_op_id(rs_out_op_id), .rs_out_pc(rs_out_pc),
    .rs_out_rs1(rs_out_rs1), .rs_out_rs2(rs_out_rs2), .rs_out_imm(rs_out_imm),
    .rs_out_rob_id(rs_out_rob_id), .rob_rollback(rob_rollback)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 0; disp_op_id = '0; disp_pc = '0; disp_vj = '0; disp_vk = '0;
    disp_rj = 1; disp_rk = 1; disp_qj = '0; disp_qk = '0; disp_imm = '0; disp_rob_id = '0;
    alu_cdb_valid = 0; alu_cdb_rob_id = '0; alu_cdb_value = '0;
    lsb_cdb_valid = 0; lsb_cdb_rob_id = '0; lsb_cdb_value = '0;
    rob_rollback = 0;
  endtask

  task automatic do_reset();
    idle();
    rdy = 1; rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] vj,
                      input logic rj, input logic [3:0] qj, input logic [31:0] vk,
                      input logic rk, input logic [3:0] qk, input logic [31:0] imm,
                      input logic [3:0] rob);
    disp_valid = 1; disp_op_id = op; disp_pc = pc; disp_vj = vj; disp_rj = rj; disp_qj = qj;
    disp_vk = vk; disp_rk = rk; disp_qk = qk; disp_imm = imm; disp_rob_id = rob;
  endtask

  // ---------------- behavioural reference model ----------------
  logic        m_busy [RS];
  logic        m_rj [RS], m_rk [RS];
  logic [3:0]  m_qj [RS], m_qk [RS], m_rob [RS];
  logic [31:0] m_vj [RS], m_vk [RS], m_imm [RS], m_pc [RS];
  logic [5:0]  m_op [RS];
  int          m_seq [RS];
  int          seq_ctr;
  logic        e_valid, e_full;
  logic [5:0]  e_op;
  logic [31:0] e_pc, e_rs1, e_rs2, e_imm;
  logic [3:0]  e_rob;

  function automatic logic tb_hit(input logic [3:0] q);
    return (alu_cdb_valid && alu_cdb_rob_id == q) || (lsb_cdb_valid && lsb_cdb_rob_id == q);
  endfunction

  function automatic logic [31:0] tb_val(input logic [3:0] q);
    return (alu_cdb_valid && alu_cdb_rob_id == q) ? alu_cdb_value : lsb_cdb_value;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < RS; i++) m_busy[i] = 0;
    seq_ctr = 0;
    e_valid = 0; e_full = 0; e_op = '0; e_pc = '0; e_rs1 = '0; e_rs2 = '0; e_imm = '0; e_rob = '0;
  endtask

  // Predict the effect of the coming clock edge from the inputs currently applied
  task automatic model_edge();
    int iss, fr, nfree;
    if (rst) begin
      model_reset();
    end else if (rdy && rob_rollback) begin
      for (int i = 0; i < RS; i++) m_busy[i] = 0;
      e_valid = 0; e_full = 0;
    end else if (rdy) begin
      iss = -1;
      for (int i = 0; i < RS; i++) begin
        if (m_busy[i] && m_rj[i] && m_rk[i]) begin
          if (iss < 0) iss = i;
`ifdef ALU_RS_OLDEST_FIRST_EN
          else if (m_seq[i] < m_seq[iss]) iss = i;
`endif
        end
      end
      e_valid = (iss >= 0);
      if (iss >= 0) begin
        e_op = m_op[iss]; e_pc = m_pc[iss]; e_rs1 = m_vj[iss]; e_rs2 = m_vk[iss];
        e_imm = m_imm[iss]; e_rob = m_rob[iss];
      end
      fr = -1;
      for (int i = 0; i < RS; i++) if (!m_busy[i] && fr < 0) fr = i;
      for (int i = 0; i < RS; i++) begin
        if (m_busy[i] && !m_rj[i] && tb_hit(m_qj[i])) begin m_vj[i] = tb_val(m_qj[i]); m_rj[i] = 1; end
        if (m_busy[i] && !m_rk[i] && tb_hit(m_qk[i])) begin m_vk[i] = tb_val(m_qk[i]); m_rk[i] = 1; end
      end
      if (iss >= 0) m_busy[iss] = 0;
      if (disp_valid && fr >= 0) begin
        m_busy[fr] = 1; m_op[fr] = disp_op_id; m_pc[fr] = disp_pc; m_imm[fr] = disp_imm;
        m_rob[fr] = disp_rob_id; m_qj[fr] = disp_qj; m_qk[fr] = disp_qk;
        m_rj[fr] = disp_rj || tb_hit(disp_qj);
        m_vj[fr] = (!disp_rj && tb_hit(disp_qj)) ? tb_val(disp_qj) : disp_vj;
        m_rk[fr] = disp_rk || tb_hit(disp_qk);
        m_vk[fr] = (!disp_rk && tb_hit(disp_qk)) ? tb_val(disp_qk) : disp_vk;
        m_seq[fr] = seq_ctr; seq_ctr++;
      end
      nfree = 0;
      for (int i = 0; i < RS; i++) if (!m_busy[i]) nfree++;
      e_full = (nfree <= 1);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rj, rk;
    logic [3:0]  qj, qk;
    logic [31:0] vj, vk;
    logic        av;
    logic [3:0]  aid;
    logic [31:0] aval;
    logic        lv;
    logic [3:0]  lid;
    logic [31:0] lval;
    logic        ev;
    logic [31:0] e1, e2;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int issued, first_pc, second_pc;
    logic saw_dropped;

    vecs[0] = '{1, 1, 4'd0, 4'd0, 32'd5, 32'd3, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 1, 32'd5, 32'd3};
    vecs[1] = '{1, 0, 4'd0, 4'd3, 32'd1, 32'd0, 0, 4'd0, 32'd0, 1, 4'd3, 32'hAB, 1, 32'd1, 32'hAB};
    vecs[2] = '{0, 1, 4'd4, 4'd0, 32'd0, 32'd7, 1, 4'd4, 32'h11, 0, 4'd0, 32'd0, 1, 32'h11, 32'd7};
    vecs[3] = '{0, 1, 4'd6, 4'd0, 32'd0, 32'd2, 1, 4'd6, 32'h22, 1, 4'd6, 32'h33, 1, 32'h22, 32'd2};
    vecs[4] = '{0, 1, 4'd0, 4'd0, 32'd0, 32'd2, 1, 4'd1, 32'h55, 0, 4'd0, 32'd0, 0, 32'd0, 32'd0};
    vecs[5] = '{0, 0, 4'd0, 4'd0, 32'd0, 32'd0, 0, 4'd0, 32'd0, 1, 4'd0, 32'h77, 1, 32'h77, 32'h77};
    vecs[6] = '{0, 0, 4'd2, 4'd5, 32'd0, 32'd0, 1, 4'd5, 32'h9, 1, 4'd2, 32'h8, 1, 32'h8, 32'h9};

    do_reset();
    chk("reset_valid", 64'(rs_out_valid), 64'd0);
    chk("reset_full", 64'(rs_full), 64'd0);
    chk("reset_op", 64'(rs_out_op_id), 64'd0);
    chk("reset_rs1", 64'(rs_out_rs1), 64'd0);
    chk("reset_rob", 64'(rs_out_rob_id), 64'd0);

    for (int k = 0; k < 7; k++) begin
      do_reset();
      disp(OP_ADDI, 32'h1000 + 32'(k), vecs[k].vj, vecs[k].rj, vecs[k].qj, vecs[k].vk,
           vecs[k].rk, vecs[k].qk, 32'h100 + 32'(k), 4'(k + 2));
      alu_cdb_valid = vecs[k].av; alu_cdb_rob_id = vecs[k].aid; alu_cdb_value = vecs[k].aval;
      lsb_cdb_valid = vecs[k].lv; lsb_cdb_rob_id = vecs[k].lid; lsb_cdb_value = vecs[k].lval;
      tick();
      chk($sformatf("vec%0d_disp_edge_valid", k), 64'(rs_out_valid), 64'd0);
      idle();
      tick();
      chk($sformatf("vec%0d_valid", k), 64'(rs_out_valid), 64'(vecs[k].ev));
      if (vecs[k].ev) begin
        chk($sformatf("vec%0d_rs1", k), 64'(rs_out_rs1), 64'(vecs[k].e1));
        chk($sformatf("vec%0d_rs2", k), 64'(rs_out_rs2), 64'(vecs[k].e2));
        chk($sformatf("vec%0d_imm", k), 64'(rs_out_imm), 64'(32'h100 + 32'(k)));
        chk($sformatf("vec%0d_rob", k), 64'(rs_out_rob_id), 64'(k + 2));
        chk($sformatf("vec%0d_op", k), 64'(rs_out_op_id), 64'(OP_ADDI));
      end
    end

    // Operand woken two cycles after dispatch
    do_reset();
    disp(OP_ADD, 32'h40, 32'd0, 0, 4'd7, 32'd1, 1, 4'd0, 32'd0, 4'd1);
    tick(); idle();
    tick();
    chk("late_wake_t1", 64'(rs_out_valid), 64'd0);
    alu_cdb_valid = 1; alu_cdb_rob_id = 4'd7; alu_cdb_value = 32'h10;
    tick(); idle();
    chk("late_wake_edge", 64'(rs_out_valid), 64'd0);
    tick();
    chk("late_wake_valid", 64'(rs_out_valid), 64'd1);
    chk("late_wake_rs1", 64'(rs_out_rs1), 64'h10);
    chk("late_wake_op", 64'(rs_out_op_id), 64'(OP_ADD));

    // Fill: 15 leaves one free -> full; 16th accepted; 17th dropped
    do_reset();
    for (int k = 0; k < 17; k++) begin
      disp(OP_ADD, 32'(k), 32'd0, 0, 4'd9, 32'd0, 1, 4'd0, 32'd0, 4'(k));
      tick();
      if (k == 13) chk("fill14_full", 64'(rs_full), 64'd0);
      if (k == 14) chk("fill15_full", 64'(rs_full), 64'd1);
      if (k == 15) chk("fill16_full", 64'(rs_full), 64'd1);
    end
    idle();
    lsb_cdb_valid = 1; lsb_cdb_rob_id = 4'd9; lsb_cdb_value = 32'h5;
    tick(); idle();
    issued = 0; saw_dropped = 0;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (rs_out_valid) begin
        issued++;
        if (rs_out_pc == 32'd16) saw_dropped = 1;
      end
    end
    chk("fill_issue_count", 64'(issued), 64'd16);
    chk("fill_dropped_absent", 64'(saw_dropped), 64'd0);
    chk("fill_drained_full", 64'(rs_full), 64'd0);

    // Rollback with six waiting entries and an issue in flight
    do_reset();
    for (int k = 0; k < 6; k++) begin
      disp(OP_ADD, 32'(k), 32'd0, 0, 4'd9, 32'd0, 1, 4'd0, 32'd0, 4'(k));
      tick();
    end
    disp(OP_ADDI, 32'd6, 32'd1, 1, 4'd0, 32'd0, 1, 4'd0, 32'd0, 4'd6);
    tick(); idle();
    tick();
    chk("rb_pre_valid", 64'(rs_out_valid), 64'd1);
    rob_rollback = 1;
    disp(OP_ADDI, 32'd99, 32'd1, 1, 4'd0, 32'd0, 1, 4'd0, 32'd0, 4'd9);
    tick(); idle();
    chk("rb_valid", 64'(rs_out_valid), 64'd0);
    chk("rb_full", 64'(rs_full), 64'd0);
    alu_cdb_valid = 1; alu_cdb_rob_id = 4'd9; alu_cdb_value = 32'h1;
    tick(); idle();
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("rb_no_issue_%0d", c), 64'(rs_out_valid), 64'd0);
    end
    disp(OP_ADDI, 32'd77, 32'd1, 1, 4'd0, 32'd0, 1, 4'd0, 32'd0, 4'd3);
    tick(); idle();
    tick();
    chk("rb_after_valid", 64'(rs_out_valid), 64'd1);
    chk("rb_after_pc", 64'(rs_out_pc), 64'd77);

    // Entry 5 older than entry 1, both become ready together
    do_reset();
    for (int k = 0; k < 6; k++) begin
      disp(OP_ADD, 32'(k), 32'd0, 0, (k == 1) ? 4'd11 : ((k == 5) ? 4'd10 : 4'd12),
           32'd0, 1, 4'd0, 32'd0, 4'(k));
      tick();
    end
    idle();
    alu_cdb_valid = 1; alu_cdb_rob_id = 4'd11; alu_cdb_value = 32'h3;
    tick(); idle();
    tick();
    chk("age_e1_issue_pc", 64'(rs_out_pc), 64'd1);
    disp(OP_ADD, 32'd100, 32'd0, 0, 4'd10, 32'd0, 1, 4'd0, 32'd0, 4'd13);
    tick(); idle();
    alu_cdb_valid = 1; alu_cdb_rob_id = 4'd10; alu_cdb_value = 32'h4;
    tick(); idle();
`ifdef ALU_RS_OLDEST_FIRST_EN
    first_pc = 5; second_pc = 100;
`else
    first_pc = 100; second_pc = 5;
`endif
    tick();
    chk("age_first_valid", 64'(rs_out_valid), 64'd1);
    chk("age_first_pc", 64'(rs_out_pc), 64'(first_pc));
    tick();
    chk("age_second_valid", 64'(rs_out_valid), 64'd1);
    chk("age_second_pc", 64'(rs_out_pc), 64'(second_pc));

    // Randomized run against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      rob_rollback = ($urandom_range(0, 59) == 0);
      disp_valid = ($urandom_range(0, 1) == 1) && (!rs_full || $urandom_range(0, 9) == 0);
      disp_op_id = 6'($urandom); disp_pc = $urandom; disp_imm = $urandom;
      disp_vj = $urandom; disp_vk = $urandom;
      disp_rj = ($urandom_range(0, 1) == 1); disp_rk = ($urandom_range(0, 1) == 1);
      disp_qj = 4'($urandom); disp_qk = 4'($urandom); disp_rob_id = 4'($urandom);
      alu_cdb_valid = ($urandom_range(0, 4) < 2); alu_cdb_rob_id = 4'($urandom);
      alu_cdb_value = $urandom;
      lsb_cdb_valid = ($urandom_range(0, 4) < 2); lsb_cdb_rob_id = 4'($urandom);
      lsb_cdb_value = $urandom;
      model_edge();
      tick();
      chk("rnd_valid", 64'(rs_out_valid), 64'(e_valid));
      chk("rnd_full", 64'(rs_full), 64'(e_full));
      chk("rnd_op", 64'(rs_out_op_id), 64'(e_op));
      chk("rnd_pc", 64'(rs_out_pc), 64'(e_pc));
      chk("rnd_rs1", 64'(rs_out_rs1), 64'(e_rs1));
      chk("rnd_rs2", 64'(rs_out_rs2), 64'(e_rs2));
      chk("rnd_imm", 64'(rs_out_imm), 64'(e_imm));
      chk("rnd_rob", 64'(rs_out_rob_id), 64'(e_rob));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
